// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the sram-like responder: size encodings, lane masks,
// and the response-queue entry layout.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int DATA_W = 32;
  // Wide enough for LATENCY-1 (max 14) plus up to 3 randomised extra cycles.
  localparam int CNT_W  = 5;

  typedef struct packed {
    logic              is_read;
    logic [DATA_W-1:0] rdata;
    logic [CNT_W-1:0]  cnt;
  } entry_t;

  localparam int ENTRY_W = 1 + DATA_W + CNT_W;

  // Byte lanes legitimately covered by an access of this size at this offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      SIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: lane_mask = 4'b1111;
      default:   lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sram_like_if.sv
// Sram-like request/response bus between a CPU port (master) and a memory responder (slave).
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata, err
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata, err
  );
endinterface

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: circular buffer of outstanding entries, each counting down
// its own latency; the head retires once its count reaches zero.
module sram_like_resp_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_entry,
  output logic   retire,
  output entry_t head,
  output logic   full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  entry_t           q [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CW-1:0]    cnt_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head   = q[head_ptr];
  assign full   = (cnt_q == CW'(DEPTH));
  assign retire = (cnt_q != '0) && (q[head_ptr].cnt == '0);

  // NOTE: non-blocking assignments throughout, so every entry sees the pre-edge state
  // and the later push write cleanly overrides the countdown of the slot it lands in.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].cnt != '0) q[i].cnt <= q[i].cnt - CNT_W'(1);
      end
      if (push) begin
        q[tail_ptr] <= push_entry;
        tail_ptr    <= next_ptr(tail_ptr);
      end
      if (retire) head_ptr <= next_ptr(head_ptr);
      case ({push, retire})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// Sram-like bus slave: word memory, accept/err logic, in-order delayed responses.
// Optional SRAM_LIKE_RAND_DELAY_EN adds LFSR-driven accept throttling and extra latency.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int DEPTH_LOG2      = 12,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic         clk,
  input  logic         reset,
  sram_like_if.slave   bus
);

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  reset_q;
  logic                  err_q;
  logic                  throttle;
  logic [1:0]            extra;
  logic                  accept;
  logic                  violation;
  logic [3:0]            mask;
  logic                  full;
  logic                  retire;
  entry_t                head;
  entry_t                push_entry;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the same word.
  assign idx            = bus.addr[DEPTH_LOG2+1:2];
  assign unused_addr_hi = ^bus.addr[31:DEPTH_LOG2+2];

  assign bus.addr_ok = !reset_q && !full && !throttle;
  assign accept      = bus.req && bus.addr_ok && !reset;

  assign mask      = lane_mask(bus.size, bus.addr[1:0]);
  assign violation = (bus.size == 2'd3)
                  || ((bus.size == SIZE_HALF) && bus.addr[0])
                  || ((bus.size == SIZE_WORD) && (bus.addr[1:0] != 2'b00))
                  || (bus.wr && ((bus.wstrb & ~mask) != 4'b0000));

  // NOTE: every field gets a value on every path so no latch is inferred.
  always_comb begin
    push_entry         = '0;
    push_entry.is_read = !bus.wr;
    push_entry.rdata   = bus.wr ? '0 : mem[idx];
    push_entry.cnt     = CNT_W'(LATENCY - 1) + CNT_W'(extra);
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

  always_ff @(posedge clk) begin
    if (reset)                     err_q <= 1'b0;
    else if (accept && violation)  err_q <= 1'b1;
  end

  // NOTE: the memory array is deliberately left out of reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

`ifdef SRAM_LIKE_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign throttle = (lfsr[1:0] == 2'b00);
  assign extra    = lfsr[3:2];
`else
  assign throttle = 1'b0;
  assign extra    = 2'b00;
`endif

  sram_like_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .retire     (retire),
    .head       (head),
    .full       (full)
  );

  assign bus.data_ok = retire;
  assign bus.rdata   = (retire && head.is_read) ? head.rdata : '0;
  assign bus.err     = err_q;

endmodule
